// File: rtl/game_mem_pkg.sv
// Shared definitions for the game memory arbiter: default word addresses,
// FSM state encoding, requester ids and grant vector bit positions.
// Optional feature macro used by this block: GAME_MEM_ARB_RR_EN.
package game_mem_pkg;

  localparam logic [4:0] SCORE_ADDR_DEF   = 5'd0;
  localparam logic [4:0] HISCORE_ADDR_DEF = 5'd1;

  // Bit positions inside the 3-bit request / one-hot grant vectors
  localparam int unsigned GNT_HS   = 0;
  localparam int unsigned GNT_DP   = 1;
  localparam int unsigned GNT_DISP = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_XFER,
    ST_WAIT,
    ST_CAPT,
    ST_DONE,
    ST_HS_RS,
    ST_HS_RSW,
    ST_HS_RH,
    ST_HS_RHW,
    ST_HS_WR,
    ST_HS_DONE
  } fsm_state_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_HS,
    REQ_DP,
    REQ_DISP
  } req_id_e;

endpackage

// File: rtl/game_mem_pick.sv
// Request picker: high-score sequence always wins; datapath vs display is
// fixed priority (dp first) by default, or round-robin when
// GAME_MEM_ARB_RR_EN is defined. Grants are only issued while en_i is high.
module game_mem_pick
  import game_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o
);

`ifdef GAME_MEM_ARB_RR_EN
  logic prefer_disp_q, prefer_disp_d;

  // Round-robin pick; the loser of the last dp/disp grant is favoured next
  always_comb begin
    gnt_o         = 3'b000;
    prefer_disp_d = prefer_disp_q;
    if (en_i) begin
      if (req_i[GNT_HS]) begin
        gnt_o[GNT_HS] = 1'b1;
      end else if (req_i[GNT_DP] && (!req_i[GNT_DISP] || !prefer_disp_q)) begin
        gnt_o[GNT_DP] = 1'b1;
        prefer_disp_d = 1'b1;
      end else if (req_i[GNT_DISP]) begin
        gnt_o[GNT_DISP] = 1'b1;
        prefer_disp_d   = 1'b0;
      end
    end
  end

  // Pointer starts out favouring the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prefer_disp_q <= 1'b0;
    else        prefer_disp_q <= prefer_disp_d;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  // Fixed priority: hs > dp > disp
  always_comb begin
    gnt_o = 3'b000;
    if (en_i) begin
      if (req_i[GNT_HS])        gnt_o[GNT_HS]   = 1'b1;
      else if (req_i[GNT_DP])   gnt_o[GNT_DP]   = 1'b1;
      else if (req_i[GNT_DISP]) gnt_o[GNT_DISP] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/game_mem_arbiter.sv
// Sequencer/arbiter for the shared 32x8 single-port game memory. Serialises
// datapath read/write and display reads, and runs the high-score update
// (read score, read hiscore, write score back if larger).
// Optional feature macro: GAME_MEM_ARB_RR_EN (round-robin dp/disp pick).
module game_mem_arbiter
  import game_mem_pkg::*;
#(
  parameter int unsigned RD_LAT       = 1,
  parameter logic [4:0]  SCORE_ADDR   = SCORE_ADDR_DEF,
  parameter logic [4:0]  HISCORE_ADDR = HISCORE_ADDR_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       dp_req,
  input  logic       dp_we,
  input  logic [4:0] dp_addr,
  input  logic [7:0] dp_wdata,
  output logic       dp_ack,
  output logic [7:0] dp_rdata,
  input  logic       disp_req,
  input  logic [4:0] disp_addr,
  output logic       disp_ack,
  output logic [7:0] disp_rdata,
  input  logic       hs_update,
  output logic       hs_new,
  output logic [7:0] hiscore,
  output logic       busy,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_wren,
  input  logic [7:0] mem_q
);

  // Extra wait cycles in the HS read states beyond the first
  localparam logic WAIT_INIT = (RD_LAT == 2) ? 1'b1 : 1'b0;

  fsm_state_e state_q, state_d;
  req_id_e    owner_q, owner_d;
  logic       we_q, we_d;
  logic       hs_pending_q, hs_pending_d;
  logic [7:0] score_q, score_d;
  logic       taken_q, taken_d;
  logic       wcnt_q, wcnt_d;
  logic [4:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       mem_wren_q, mem_wren_d;
  logic       dp_ack_q, dp_ack_d;
  logic       disp_ack_q, disp_ack_d;
  logic [7:0] dp_rdata_q, dp_rdata_d;
  logic [7:0] disp_rdata_q, disp_rdata_d;
  logic       hs_new_q, hs_new_d;
  logic [7:0] hiscore_q, hiscore_d;
  logic [2:0] gnt;

  game_mem_pick u_pick (
    .clk   (clk),
    .rst_n (resetn),
    .en_i  (state_q == ST_IDLE),
    .req_i ({disp_req, dp_req, hs_pending_q}),
    .gnt_o (gnt)
  );

  // Next-state logic for the transfer and high-score sequences
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    hs_pending_d = hs_pending_q | hs_update;
    score_d      = score_q;
    taken_d      = taken_q;
    wcnt_d       = wcnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wren_d   = 1'b0;
    dp_ack_d     = 1'b0;
    disp_ack_d   = 1'b0;
    dp_rdata_d   = dp_rdata_q;
    disp_rdata_d = disp_rdata_q;
    hs_new_d     = 1'b0;
    hiscore_d    = hiscore_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt[GNT_HS]) begin
          // A pulse coinciding with the grant merges into this sequence
          hs_pending_d = 1'b0;
          owner_d      = REQ_HS;
          mem_addr_d   = SCORE_ADDR;
          state_d      = ST_HS_RS;
        end else if (gnt[GNT_DP]) begin
          owner_d     = REQ_DP;
          we_d        = dp_we;
          mem_addr_d  = dp_addr;
          mem_wdata_d = dp_wdata;
          mem_wren_d  = dp_we;
          state_d     = ST_XFER;
        end else if (gnt[GNT_DISP]) begin
          owner_d    = REQ_DISP;
          we_d       = 1'b0;
          mem_addr_d = disp_addr;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (we_q) begin
          dp_ack_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d = (RD_LAT == 2) ? ST_WAIT : ST_CAPT;
        end
      end
      ST_WAIT: state_d = ST_CAPT;
      ST_CAPT: begin
        if (owner_q == REQ_DP) begin
          dp_rdata_d = mem_q;
          dp_ack_d   = 1'b1;
        end else begin
          disp_rdata_d = mem_q;
          disp_ack_d   = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        owner_d = REQ_NONE;
        state_d = ST_IDLE;
      end
      ST_HS_RS: begin
        wcnt_d  = WAIT_INIT;
        state_d = ST_HS_RSW;
      end
      ST_HS_RSW: begin
        if (wcnt_q) begin
          wcnt_d = 1'b0;
        end else begin
          score_d    = mem_q;
          mem_addr_d = HISCORE_ADDR;
          state_d    = ST_HS_RH;
        end
      end
      ST_HS_RH: begin
        wcnt_d  = WAIT_INIT;
        state_d = ST_HS_RHW;
      end
      ST_HS_RHW: begin
        if (wcnt_q) begin
          wcnt_d = 1'b0;
        end else begin
          // Unsigned compare; the write is issued on entry to HS_WR
          if (score_q > mem_q) begin
            taken_d     = 1'b1;
            mem_wren_d  = 1'b1;
            mem_wdata_d = score_q;
            hiscore_d   = score_q;
          end else begin
            taken_d   = 1'b0;
            hiscore_d = mem_q;
          end
          state_d = ST_HS_WR;
        end
      end
      ST_HS_WR: begin
        hs_new_d = taken_q;
        state_d  = ST_HS_DONE;
      end
      ST_HS_DONE: begin
        owner_d = REQ_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any sequence at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_NONE;
      we_q         <= 1'b0;
      hs_pending_q <= 1'b0;
      score_q      <= 8'h00;
      taken_q      <= 1'b0;
      wcnt_q       <= 1'b0;
      mem_addr_q   <= 5'd0;
      mem_wdata_q  <= 8'h00;
      mem_wren_q   <= 1'b0;
      dp_ack_q     <= 1'b0;
      disp_ack_q   <= 1'b0;
      dp_rdata_q   <= 8'h00;
      disp_rdata_q <= 8'h00;
      hs_new_q     <= 1'b0;
      hiscore_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      hs_pending_q <= hs_pending_d;
      score_q      <= score_d;
      taken_q      <= taken_d;
      wcnt_q       <= wcnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wren_q   <= mem_wren_d;
      dp_ack_q     <= dp_ack_d;
      disp_ack_q   <= disp_ack_d;
      dp_rdata_q   <= dp_rdata_d;
      disp_rdata_q <= disp_rdata_d;
      hs_new_q     <= hs_new_d;
      hiscore_q    <= hiscore_d;
    end
  end

  assign dp_ack     = dp_ack_q;
  assign dp_rdata   = dp_rdata_q;
  assign disp_ack   = disp_ack_q;
  assign disp_rdata = disp_rdata_q;
  assign hs_new     = hs_new_q;
  assign hiscore    = hiscore_q;
  assign busy       = (state_q != ST_IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wren   = mem_wren_q;

endmodule
